llc_sched: RTL and testbench
============================

# llc_sched

LLC front-end scheduler. Arbitrates the LLC's input channels (reset/flush, L2 responses, L2 requests, DMA requests, plus resumption of stalled requests and DMA bursts) into a single transaction stream. Sequences each granted transaction through decode and processing, and drives the per-set sweep used by reset and flush. Sits between the LLC input queues and the LLC decode/process pipeline, consuming the stall/pending flags held in the LLC register bank.

## Interface
- `SETS`, 256: number of LLC sets swept on reset/flush.
- `SET_W`, 8: width of the set index; `2**SET_W >= SETS`.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rst_valid` in 1 / `rst_ready` out 1: reset/flush request handshake.
- `rst_is_flush` in 1: qualifies `rst_valid`; 1 = flush, 0 = reset.
- `rsp_valid` in 1 / `rsp_ready` out 1: L2 response handshake.
- `req_valid` in 1 / `req_ready` out 1: L2 request handshake.
- `dma_valid` in 1 / `dma_ready` out 1: DMA request handshake.
- `req_stall` in 1: a request is blocked on a set conflict.
- `req_in_stalled_valid` in 1: a stalled request is held for replay.
- `recall_pending` in 1: a recall is outstanding.
- `dma_to_resume` in 1: a multi-line DMA read/write is mid-burst.
- `proc_done` in 1: pulse, the process stage finished the current transaction.
- `sel` out 3: current transaction source. 0 none, 1 sweep, 2 rsp, 3 req, 4 dma, 5 req_resume, 6 dma_resume.
- `decode_en` out 1: one-cycle pulse starting decode of `sel`.
- `sweep_set` out SET_W: set index for the current sweep step.
- `sweep_is_flush` out 1: latched `rst_is_flush` for the active sweep.
- `sweep_done` out 1: one-cycle pulse after the last set completes.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, DECODE, PROC, SWEEP, SWEEP_WAIT.

IDLE
- The block grants at most one source per cycle. A handshake completes when valid and ready are both high in the same cycle.
- Priority, highest first:
  1. `rst_valid`.
  2. req_resume, when `req_in_stalled_valid & !req_stall`.
  3. dma_resume, when `dma_to_resume & !recall_pending`.
  4. `rsp_valid`.
  5. req/dma.
- Eligibility for priority 5:
  - `req_valid` requires `!req_stall & !recall_pending & !req_in_stalled_valid`.
  - `dma_valid` requires `!dma_to_resume & !recall_pending`.
- Req vs dma uses a round-robin bit `rr`.
  - `rr` = 0 favours req; `rr` = 1 favours dma.
  - `rr` updates only on a req or dma grant: it is set to 1 after req wins and to 0 after dma wins.
- Granting rsp, req or dma:
  - assert the matching `*_ready` that cycle;
  - latch `sel`;
  - go to DECODE.
- Granting a resume: no ready is asserted; latch `sel` = 5 or 6 and go to DECODE.
- Granting rst:
  - assert `rst_ready`;
  - latch `sweep_is_flush`;
  - clear the set counter to 0;
  - set `sel` = 1;
  - go to SWEEP.

Other states
- DECODE: `decode_en` = 1 for one cycle, then go to PROC.
- PROC: hold `sel` until `proc_done`. On `proc_done`, set `sel` = 0 and go to IDLE.
- SWEEP: `decode_en` = 1 for one cycle with `sweep_set` = counter, then go to SWEEP_WAIT.
- SWEEP_WAIT, on `proc_done`:
  - if counter = SETS-1: pulse `sweep_done`, set `sel` = 0, go to IDLE;
  - otherwise: increment the counter and go to SWEEP.

General rules
- `*_ready` outputs are combinational (Mealy) from state and inputs. They are high only in IDLE.
- Nothing preempts PROC or a sweep. A `rst_valid` arriving mid-transaction waits for IDLE.
- `proc_done` outside PROC or SWEEP_WAIT is ignored.
- The set counter never wraps past SETS-1; `sweep_set` holds its value outside a sweep.

## Timing
- Reset (sync, `rst` = 1 at a clock edge) forces:
  - state IDLE;
  - `sel` = 0, `decode_en` = 0, `sweep_set` = 0, `sweep_is_flush` = 0, `sweep_done` = 0, `busy` = 0;
  - `rr` = 0.
- While `rst` = 1, all `*_ready` outputs are 0.
- Reset mid-sweep or mid-PROC abandons the transaction. No `sweep_done` is produced.
- Grant in cycle N gives `decode_en` in cycle N+1. `proc_done` in cycle M gives IDLE in cycle M+1, so the next grant is possible in M+1.
- Minimum spacing between two grants is 3 cycles: a `proc_done` in the cycle after decode gives grant N, decode N+1, done N+2, grant N+3.
- Sweep length is at least 2·SETS cycles. `sweep_done` is asserted in the cycle after the final `proc_done`, together with the return to IDLE.
- `busy` = 0 exactly in IDLE.
- Simultaneous inputs follow strict priority. For example, `rst_valid` and `rsp_valid` both high in IDLE: only `rst_ready` rises.

## Test plan
- **Reset sweep:** `rst_valid`=1, `rst_is_flush`=0, SETS=4, `proc_done` one cycle after each decode. Expect `rst_ready` pulse, `sweep_set` 0,1,2,3 with one `decode_en` each, then `sweep_done` pulse, `busy`=0, `sweep_is_flush`=0.
- **Priority:** `rsp_valid`, `req_valid`, `dma_valid` all held at 1. Expect rsp granted first (`sel`=2). After its `proc_done`, rsp dropped: req granted (`sel`=3), then dma (`sel`=4).
- **Round-robin:** `req_valid` and `dma_valid` held at 1 for 6 grants. Expect `sel` sequence 3,4,3,4,3,4.
- **Stall gating:** `recall_pending`=1, `req_valid`=`dma_valid`=1. Expect no grant. Raise `rsp_valid`: expect `rsp_ready` and `sel`=2. Clear `recall_pending`: req/dma resume normally.
- **Resume:** `req_in_stalled_valid`=1, `req_stall`=1, `req_valid`=1. Expect no req grant. Drop `req_stall`: expect `sel`=5 with `req_ready`=0.
- **Reset mid-operation:** `rst` asserted in SWEEP_WAIT at set 2. Expect next cycle IDLE, `sweep_set`=0, no `sweep_done`. A new `rst_valid` restarts the sweep at set 0.

Source files
------------

// File: rtl/llc_sched.sv
// llc_sched: LLC front-end scheduler.
// Picks at most one input source per cycle: reset/flush, request replay,
// DMA burst resume, L2 response, or L2 request/DMA with round-robin between them.
// It steps each granted transaction through decode and process.
// For reset/flush it walks every set once, doing one decode/process pair per set.
module llc_sched #(
    parameter int SETS  = 256,
    parameter int SET_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             rst_valid,
    output logic             rst_ready,
    input  logic             rst_is_flush,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             dma_valid,
    output logic             dma_ready,

    input  logic             req_stall,
    input  logic             req_in_stalled_valid,
    input  logic             recall_pending,
    input  logic             dma_to_resume,
    input  logic             proc_done,

    output logic [2:0]       sel,
    output logic             decode_en,
    output logic [SET_W-1:0] sweep_set,
    output logic             sweep_is_flush,
    output logic             sweep_done,
    output logic             busy
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_DECODE     = 3'd1;
    localparam logic [2:0] ST_PROC       = 3'd2;
    localparam logic [2:0] ST_SWEEP      = 3'd3;
    localparam logic [2:0] ST_SWEEP_WAIT = 3'd4;

    // Transaction source codes driven on sel
    localparam logic [2:0] SEL_NONE       = 3'd0;
    localparam logic [2:0] SEL_SWEEP      = 3'd1;
    localparam logic [2:0] SEL_RSP        = 3'd2;
    localparam logic [2:0] SEL_REQ        = 3'd3;
    localparam logic [2:0] SEL_DMA        = 3'd4;
    localparam logic [2:0] SEL_REQ_RESUME = 3'd5;
    localparam logic [2:0] SEL_DMA_RESUME = 3'd6;

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    logic [2:0] state;
    logic       rr;             // 0: req wins a req/dma tie, 1: dma wins

    // Source eligibility, independent of state
    logic req_resume_ok;
    logic dma_resume_ok;
    logic req_elig;
    logic dma_elig;

    // One-hot grant strobes, only ever active in IDLE outside reset
    logic grant_rst;
    logic grant_req_resume;
    logic grant_dma_resume;
    logic grant_rsp;
    logic grant_req;
    logic grant_dma;

    assign req_resume_ok = req_in_stalled_valid & ~req_stall;
    assign dma_resume_ok = dma_to_resume & ~recall_pending;
    assign req_elig      = req_valid & ~req_stall & ~recall_pending & ~req_in_stalled_valid;
    assign dma_elig      = dma_valid & ~dma_to_resume & ~recall_pending;

    // Fixed-priority arbitration with a round-robin tie-break between req and dma
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        grant_rst        = 1'b0;
        grant_req_resume = 1'b0;
        grant_dma_resume = 1'b0;
        grant_rsp        = 1'b0;
        grant_req        = 1'b0;
        grant_dma        = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (rst_valid) begin
                grant_rst = 1'b1;
            end else if (req_resume_ok) begin
                grant_req_resume = 1'b1;
            end else if (dma_resume_ok) begin
                grant_dma_resume = 1'b1;
            end else if (rsp_valid) begin
                grant_rsp = 1'b1;
            end else if (req_elig && dma_elig) begin
                grant_req = ~rr;
                grant_dma = rr;
            end else begin
                grant_req = req_elig;
                grant_dma = dma_elig;
            end
        end
    end

    // Resume grants take no handshake, so they have no ready output.
    assign rst_ready = grant_rst;
    assign rsp_ready = grant_rsp;
    assign req_ready = grant_req;
    assign dma_ready = grant_dma;

    assign decode_en = (state == ST_DECODE) || (state == ST_SWEEP);
    assign busy      = (state != ST_IDLE);

    // State, selected source, sweep counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sel            <= SEL_NONE;
            sweep_set      <= '0;
            sweep_is_flush <= 1'b0;
            sweep_done     <= 1'b0;
            rr             <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_rst) begin
                        sel            <= SEL_SWEEP;
                        sweep_is_flush <= rst_is_flush;
                        sweep_set      <= '0;
                        state          <= ST_SWEEP;
                    end else if (grant_req_resume) begin
                        sel   <= SEL_REQ_RESUME;
                        state <= ST_DECODE;
                    end else if (grant_dma_resume) begin
                        sel   <= SEL_DMA_RESUME;
                        state <= ST_DECODE;
                    end else if (grant_rsp) begin
                        sel   <= SEL_RSP;
                        state <= ST_DECODE;
                    end else if (grant_req) begin
                        sel   <= SEL_REQ;
                        rr    <= 1'b1;
                        state <= ST_DECODE;
                    end else if (grant_dma) begin
                        sel   <= SEL_DMA;
                        rr    <= 1'b0;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_PROC;
                end
                ST_PROC: begin
                    if (proc_done) begin
                        sel   <= SEL_NONE;
                        state <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    state <= ST_SWEEP_WAIT;
                end
                ST_SWEEP_WAIT: begin
                    if (proc_done) begin
                        if (sweep_set == LAST_SET) begin
                            sweep_done <= 1'b1;
                            sel        <= SEL_NONE;
                            state      <= ST_IDLE;
                        end else begin
                            sweep_set <= sweep_set + SET_W'(1);
                            state     <= ST_SWEEP;
                        end
                    end
                end
                default: begin
                    sel   <= SEL_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_sched.sv
// tb_llc_sched: directed self-checking bench for llc_sched with a 4-set sweep.
module tb_llc_sched;

    localparam int SETS  = 4;
    localparam int SET_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             rst_valid, rst_ready, rst_is_flush;
    logic             rsp_valid, rsp_ready;
    logic             req_valid, req_ready;
    logic             dma_valid, dma_ready;
    logic             req_stall, req_in_stalled_valid, recall_pending, dma_to_resume;
    logic             proc_done;
    logic [2:0]       sel;
    logic             decode_en;
    logic [SET_W-1:0] sweep_set;
    logic             sweep_is_flush, sweep_done, busy;

    int checks = 0;
    int errors = 0;

    llc_sched #(.SETS(SETS), .SET_W(SET_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rst_valid            (rst_valid),
        .rst_ready            (rst_ready),
        .rst_is_flush         (rst_is_flush),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .dma_valid            (dma_valid),
        .dma_ready            (dma_ready),
        .req_stall            (req_stall),
        .req_in_stalled_valid (req_in_stalled_valid),
        .recall_pending       (recall_pending),
        .dma_to_resume        (dma_to_resume),
        .proc_done            (proc_done),
        .sel                  (sel),
        .decode_en            (decode_en),
        .sweep_set            (sweep_set),
        .sweep_is_flush       (sweep_is_flush),
        .sweep_done           (sweep_done),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE with the grant already set up; expects exp_sel to win the
    // next edge, then decode one cycle, process one cycle, back to IDLE.
    task automatic run_txn(input string tag, input logic [2:0] exp_sel);
        tick();
        check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        check({tag, "_dec"}, 32'(decode_en), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nodone"}, 32'(sweep_done), 32'd0);
        tick();
        check({tag, "_dec_off"}, 32'(decode_en), 32'd0);
        check({tag, "_hold"}, 32'(sel), 32'(exp_sel));
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        check({tag, "_idle_sel"}, 32'(sel), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // Called right after the rst grant edge (SWEEP, set 0); walks all sets.
    task automatic sweep_all(input string tag, input logic flush);
        for (int i = 0; i < SETS; i++) begin
            check({tag, "_sel"}, 32'(sel), 32'd1);
            check({tag, "_dec"}, 32'(decode_en), 32'd1);
            check({tag, "_set"}, 32'(sweep_set), 32'(i));
            check({tag, "_flush"}, 32'(sweep_is_flush), 32'(flush));
            tick();
            check({tag, "_wait_dec"}, 32'(decode_en), 32'd0);
            check({tag, "_wait_done"}, 32'(sweep_done), 32'd0);
            check({tag, "_wait_rsp_rdy"}, 32'(rsp_ready), 32'd0);
            check({tag, "_wait_busy"}, 32'(busy), 32'd1);
            proc_done = 1'b1;
            tick();
            proc_done = 1'b0;
        end
        check({tag, "_done"}, 32'(sweep_done), 32'd1);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_sel"}, 32'(sel), 32'd0);
        check({tag, "_end_set"}, 32'(sweep_set), 32'(SETS - 1));
    endtask

    initial begin
        rst = 1'b1;
        rst_valid = 1'b0; rst_is_flush = 1'b0;
        rsp_valid = 1'b0; req_valid = 1'b0; dma_valid = 1'b0;
        req_stall = 1'b0; req_in_stalled_valid = 1'b0;
        recall_pending = 1'b0; dma_to_resume = 1'b0; proc_done = 1'b0;

        // Reset state, readies held low while rst is high
        tick();
        tick();
        rst_valid = 1'b1; rsp_valid = 1'b1;
        #1;
        check("rst_hold_rst_ready", 32'(rst_ready), 32'd0);
        check("rst_hold_rsp_ready", 32'(rsp_ready), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dec", 32'(decode_en), 32'd0);
        check("reset_set", 32'(sweep_set), 32'd0);
        check("reset_flush", 32'(sweep_is_flush), 32'd0);
        check("reset_done", 32'(sweep_done), 32'd0);
        tick();
        rst = 1'b0;

        // Reset sweep; rst_valid beats a simultaneous rsp_valid
        #1;
        check("sim_rst_ready", 32'(rst_ready), 32'd1);
        check("sim_rsp_ready", 32'(rsp_ready), 32'd0);
        tick();
        rst_valid = 1'b0; rsp_valid = 1'b0;
        sweep_all("sweep0", 1'b0);
        tick();
        check("sweep0_done_pulse", 32'(sweep_done), 32'd0);
        check("sweep0_set_holds", 32'(sweep_set), 32'(SETS - 1));

        // proc_done in IDLE is ignored
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_sel", 32'(sel), 32'd0);

        // Priority: rsp first, then req/dma round-robin 3,4,3,4,3,4
        rsp_valid = 1'b1; req_valid = 1'b1; dma_valid = 1'b1;
        #1;
        check("prio_rsp_ready", 32'(rsp_ready), 32'd1);
        check("prio_req_ready", 32'(req_ready), 32'd0);
        check("prio_dma_ready", 32'(dma_ready), 32'd0);
        run_txn("prio_rsp", 3'd2);
        rsp_valid = 1'b0;
        #1;
        check("rr0_req_ready", 32'(req_ready), 32'd1);
        check("rr0_dma_ready", 32'(dma_ready), 32'd0);
        run_txn("rr_req0", 3'd3);
        #1;
        check("rr1_dma_ready", 32'(dma_ready), 32'd1);
        check("rr1_req_ready", 32'(req_ready), 32'd0);
        run_txn("rr_dma0", 3'd4);
        run_txn("rr_req1", 3'd3);
        run_txn("rr_dma1", 3'd4);
        run_txn("rr_req2", 3'd3);
        run_txn("rr_dma2", 3'd4);

        // Stall gating: recall_pending blocks req/dma but not rsp
        recall_pending = 1'b1;
        #1;
        check("gate_req_ready", 32'(req_ready), 32'd0);
        check("gate_dma_ready", 32'(dma_ready), 32'd0);
        tick();
        check("gate_no_grant", 32'(busy), 32'd0);
        rsp_valid = 1'b1;
        #1;
        check("gate_rsp_ready", 32'(rsp_ready), 32'd1);
        run_txn("gate_rsp", 3'd2);
        rsp_valid = 1'b0;
        recall_pending = 1'b0;
        #1;
        check("ungate_req_ready", 32'(req_ready), 32'd1);
        run_txn("ungate_req", 3'd3);
        run_txn("ungate_dma", 3'd4);
        req_valid = 1'b0; dma_valid = 1'b0;

        // DMA burst resume waits for recall to clear; no dma_ready
        dma_to_resume = 1'b1; recall_pending = 1'b1; dma_valid = 1'b1;
        #1;
        check("dres_blk_ready", 32'(dma_ready), 32'd0);
        tick();
        check("dres_blk_busy", 32'(busy), 32'd0);
        recall_pending = 1'b0;
        #1;
        check("dres_dma_ready", 32'(dma_ready), 32'd0);
        run_txn("dma_resume", 3'd6);
        dma_to_resume = 1'b0; dma_valid = 1'b0;

        // Request replay: blocked by req_stall, then outranks rsp
        req_in_stalled_valid = 1'b1; req_stall = 1'b1; req_valid = 1'b1;
        #1;
        check("rres_blk_ready", 32'(req_ready), 32'd0);
        tick();
        check("rres_blk_busy", 32'(busy), 32'd0);
        req_stall = 1'b0; rsp_valid = 1'b1;
        #1;
        check("rres_req_ready", 32'(req_ready), 32'd0);
        check("rres_rsp_ready", 32'(rsp_ready), 32'd0);
        run_txn("req_resume", 3'd5);
        req_in_stalled_valid = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0;

        // Flush sweep interrupted by rst at set 2
        rst_valid = 1'b1; rst_is_flush = 1'b1;
        #1;
        check("flush_rst_ready", 32'(rst_ready), 32'd1);
        tick();
        rst_valid = 1'b0; rst_is_flush = 1'b0;
        check("flush_latched", 32'(sweep_is_flush), 32'd1);
        check("flush_set0", 32'(sweep_set), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            proc_done = 1'b1;
            tick();
            proc_done = 1'b0;
        end
        tick();
        check("mid_wait_set2", 32'(sweep_set), 32'd2);
        check("mid_wait_dec", 32'(decode_en), 32'd0);
        rst = 1'b1;
        proc_done = 1'b1;
        tick();
        rst = 1'b0;
        proc_done = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_set", 32'(sweep_set), 32'd0);
        check("mid_rst_done", 32'(sweep_done), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_flush", 32'(sweep_is_flush), 32'd0);
        tick();
        check("mid_rst_done_late", 32'(sweep_done), 32'd0);

        // Fresh sweep restarts at set 0; a pending rsp waits it out
        rst_valid = 1'b1;
        #1;
        check("restart_rst_ready", 32'(rst_ready), 32'd1);
        tick();
        rst_valid = 1'b0; rsp_valid = 1'b1;
        sweep_all("sweep1", 1'b0);
        check("post_sweep_rsp_ready", 32'(rsp_ready), 32'd1);
        run_txn("post_sweep_rsp", 3'd2);
        rsp_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
